uart_rx_controller: RTL and testbench
=====================================

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set receive FIFO depth in bytes (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 192, SHALL set the watchdog limit in clk2 cycles from frame start to rx_finished rise.
REQ-003 clk2  input  1  16x-baud oversampling clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  receiver enable from CPU side.
REQ-006 rx_line  input  1  serial line level, already synchronised to clk2.
REQ-007 rx_finished  input  1  receiver stop-bit indicator, high for the whole stop-bit period.
REQ-008 rx_data  input  8  receiver shift-register contents, stable while rx_finished is high.
REQ-009 rx_rst  output  1  reset to the receiver datapath.
REQ-010 rd_valid  output  1  FIFO non-empty.
REQ-011 rd_data  output  8  FIFO head byte (show-ahead).
REQ-012 rd_ready  input  1  consumer accepts head byte.
REQ-013 count  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-014 overrun  output  1  sticky: byte dropped because FIFO full.
REQ-015 framing_err  output  1  sticky: bad stop bit or watchdog expiry.
REQ-016 clr_err  input  1  single-cycle clear of overrun and framing_err.

Function
REQ-017 FSM states SHALL be DISABLED, IDLE, FRAME, STOP_CHK and RECOVER.
REQ-018 DISABLED: rx_rst=1; enable=1 SHALL move to IDLE next cycle.
REQ-019 IDLE: rx_rst=0; falling edge on rx_line (1 then 0 on consecutive cycles) SHALL move to FRAME and clear the watchdog counter.
REQ-020 FRAME: watchdog SHALL increment every cycle; rx_finished rising edge SHALL move to STOP_CHK and clear the stop counter; watchdog reaching TIMEOUT first SHALL set framing_err and move to RECOVER.
REQ-021 STOP_CHK: stop counter SHALL increment every cycle; at value 7 (8th cycle) rx_line SHALL be sampled: 1 means push rx_data into FIFO, 0 means set framing_err and drop the byte; then move to IDLE.
REQ-022 rx_finished falling before the sample cycle in STOP_CHK SHALL set framing_err, drop the byte and move to IDLE.
REQ-023 RECOVER: rx_rst=1 for exactly 2 cycles, then rx_rst=0 while waiting for 16 consecutive cycles of rx_line=1 (any 0 restarts the count), then move to IDLE.
REQ-024 enable=0 in any state SHALL move to DISABLED next cycle, aborting any frame; FIFO contents and error flags SHALL be retained.
REQ-025 Push with FIFO full and no simultaneous pop SHALL drop the byte, set overrun, and leave FIFO unchanged.
REQ-026 Pop occurs when rd_valid and rd_ready are both high; rd_ready while empty SHALL be ignored.
REQ-027 Simultaneous push and pop SHALL leave count unchanged, including when full (no overrun) or empty cannot occur since pop requires rd_valid.
REQ-028 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-029 Byte pushed at cycle N SHALL appear on rd_data with rd_valid=1 at cycle N+1 if FIFO was empty.
REQ-030 clr_err coinciding with a new error event SHALL leave the flag set (set wins).

Reset
REQ-031 reset SHALL force state DISABLED, rx_rst=1, FIFO empty, count=0, rd_valid=0, rd_data=0, overrun=0, framing_err=0, all counters 0, asynchronously.
REQ-032 Deassertion of reset SHALL take effect on the next clk2 rising edge; reset mid-frame SHALL discard the frame.

Verification
REQ-033 enable=1, frame 0x5A with valid stop bit -> rd_valid=1, rd_data=0x5A, count=1, no error flags.
REQ-034 DEPTH=4, five frames 0x01..0x05 with rd_ready=0 -> count=4, overrun=1, rd_data pops 0x01..0x04 in order.
REQ-035 Frame with rx_line=0 at stop-bit sample -> framing_err=1, count unchanged; clr_err pulse -> framing_err=0.
REQ-036 Start edge then no rx_finished for 192 cycles -> framing_err=1, rx_rst high exactly 2 cycles, return to IDLE after 16 idle-high cycles.
REQ-037 FIFO full, push and pop same cycle -> count stays 4, overrun stays 0, new byte at tail.
REQ-038 enable dropped mid-frame -> DISABLED, rx_rst=1 next cycle, stored bytes still readable.

Source files
------------

// File: rtl/uart_rx_controller.sv
// UART receive controller: stop-bit check, frame watchdog with line
// recovery, and a show-ahead byte FIFO with sticky error flags.
module uart_rx_controller #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 192
) (
  input  logic                   clk2,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   rx_line,
  input  logic                   rx_finished,
  input  logic [7:0]             rx_data,
  output logic                   rx_rst,
  output logic                   rd_valid,
  output logic [7:0]             rd_data,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  output logic                   framing_err,
  input  logic                   clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    DISABLED, IDLE, FRAME, STOP_CHK, RECOVER
  } state_t;

  state_t state, state_n;

  logic          line_q, fin_q;
  logic [WW-1:0] wdog;
  logic [2:0]    stop_cnt;
  logic [3:0]    rec_cnt;
  logic          rec_hold;

  logic fall_edge, fin_rise, wd_hit, smp;
  logic push_req, ferr_set, ovr_set;
  logic pop, full, wr_en;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign fall_edge = line_q & ~rx_line;
  assign fin_rise  = ~fin_q & rx_finished;
  assign wd_hit    = wdog == WW'(TIMEOUT - 1);
  assign smp       = stop_cnt == 3'd7;

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) state <= DISABLED;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!enable) begin
      state_n = DISABLED;
    end else begin
      unique case (state)
        DISABLED: state_n = IDLE;
        IDLE:     if (fall_edge) state_n = FRAME;
        FRAME: begin
          if (fin_rise)    state_n = STOP_CHK;
          else if (wd_hit) state_n = RECOVER;
        end
        STOP_CHK: if (smp || !rx_finished) state_n = IDLE;
        RECOVER: begin
          if (!rec_hold && rx_line && rec_cnt == 4'd15)
            state_n = IDLE;
        end
        default:  state_n = DISABLED;
      endcase
    end
  end

  always_comb begin
    rx_rst   = 1'b0;
    push_req = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      DISABLED: rx_rst = 1'b1;
      FRAME:    ferr_set = enable & ~fin_rise & wd_hit;
      STOP_CHK: begin
        push_req = enable & smp & rx_line;
        ferr_set = enable & (smp ? ~rx_line : ~rx_finished);
      end
      RECOVER:  rx_rst = rec_hold;
      default:  ;
    endcase
  end

  // Recovery holds the receiver in reset for two cycles, then waits
  // for sixteen uninterrupted idle-high samples.
  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      line_q   <= 1'b0;
      fin_q    <= 1'b0;
      wdog     <= '0;
      stop_cnt <= '0;
      rec_cnt  <= '0;
      rec_hold <= 1'b0;
    end else begin
      line_q   <= rx_line;
      fin_q    <= rx_finished;
      wdog     <= (state == FRAME) ? wdog + WW'(1) : '0;
      stop_cnt <= (state == STOP_CHK) ? stop_cnt + 3'd1 : '0;
      if (state != RECOVER) begin
        rec_hold <= 1'b1;
        rec_cnt  <= '0;
      end else if (rec_hold) begin
        rec_hold <= rec_cnt != 4'd1;
        rec_cnt  <= (rec_cnt == 4'd1) ? 4'd0 : rec_cnt + 4'd1;
      end else begin
        rec_cnt  <= rx_line ? rec_cnt + 4'd1 : 4'd0;
      end
    end
  end

  assign rd_valid = count != '0;
  assign full     = count == (AW + 1)'(DEPTH);
  assign pop      = rd_valid & rd_ready;
  assign wr_en    = push_req & (~full | pop);
  assign ovr_set  = push_req & full & ~pop;
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk2) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + (AW + 1)'(1);
      else if (pop && !wr_en) count <= count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (ferr_set)     framing_err <= 1'b1;
      else if (clr_err) framing_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: frames, FIFO limits,
// stop-bit errors, watchdog recovery, enable abort and async reset.
module tb_uart_rx_controller;
  logic       clk2 = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       rx_line = 1'b1;
  logic       rx_finished = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rd_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic       rx_rst, rd_valid, overrun, framing_err;
  logic [7:0] rd_data;
  logic [2:0] count;

  int vecs = 0;
  int errs = 0;

  always #5 clk2 = ~clk2;

  uart_rx_controller #(.DEPTH(4), .TIMEOUT(192)) dut (
    .clk2        (clk2),
    .reset       (reset),
    .enable      (enable),
    .rx_line     (rx_line),
    .rx_finished (rx_finished),
    .rx_data     (rx_data),
    .rx_rst      (rx_rst),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .count       (count),
    .overrun     (overrun),
    .framing_err (framing_err),
    .clr_err     (clr_err)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk2);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Idle-high lead-in, start edge, data period, then a 16-cycle stop
  // bit; pop=1 raises rd_ready exactly on the push edge.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic pop, input int pre);
    rx_line = 1'b1;
    cyc(pre);
    rx_line = 1'b0;
    cyc(20);
    rx_data     = d;
    rx_line     = stop;
    rx_finished = 1'b1;
    cyc(8);
    rd_ready = pop;
    cyc(1);
    rd_ready = 1'b0;
    cyc(7);
    rx_finished = 1'b0;
    rx_line     = 1'b1;
    cyc(2);
  endtask

  task automatic pop_one(input logic [7:0] exp, input string tag);
    chk(tag, rd_data, exp);
    rd_ready = 1'b1;
    cyc(1);
    rd_ready = 1'b0;
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("rst_rx_rst", rx_rst, 1);
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_ovr", overrun, 0);
    chk("rst_ferr", framing_err, 0);

    reset = 1'b0;
    cyc(2);
    chk("dis_rx_rst", rx_rst, 1);
    enable = 1'b1;
    cyc(1);
    chk("idle_rx_rst", rx_rst, 0);

    send_frame(8'h5A, 1'b1, 1'b0, 2);
    chk("f5a_valid", rd_valid, 1);
    chk("f5a_data", rd_data, 8'h5A);
    chk("f5a_count", count, 1);
    chk("f5a_ovr", overrun, 0);
    chk("f5a_ferr", framing_err, 0);
    pop_one(8'h5A, "f5a_pop");
    chk("f5a_empty", count, 0);
    chk("f5a_nvalid", rd_valid, 0);

    rd_ready = 1'b1;
    cyc(1);
    rd_ready = 1'b0;
    chk("empty_pop", count, 0);

    for (int i = 1; i <= 5; i++)
      send_frame(8'(i), 1'b1, 1'b0, 2);
    chk("ovr_count", count, 4);
    chk("ovr_flag", overrun, 1);
    chk("ovr_ferr", framing_err, 0);
    for (int i = 1; i <= 4; i++)
      pop_one(8'(i), "ovr_order");
    chk("ovr_drained", count, 0);
    clear_errs();
    chk("ovr_clr", overrun, 0);

    send_frame(8'h77, 1'b0, 1'b0, 2);
    chk("stop0_ferr", framing_err, 1);
    chk("stop0_count", count, 0);
    clear_errs();
    chk("stop0_clr", framing_err, 0);

    rx_line = 1'b1;
    cyc(2);
    rx_line = 1'b0;
    cyc(20);
    rx_data = 8'h66;
    rx_line = 1'b1;
    rx_finished = 1'b1;
    cyc(3);
    rx_finished = 1'b0;
    cyc(2);
    chk("early_ferr", framing_err, 1);
    chk("early_count", count, 0);
    clear_errs();
    chk("early_clr", framing_err, 0);

    for (int i = 0; i < 4; i++)
      send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 2);
    chk("full_count", count, 4);
    send_frame(8'h14, 1'b1, 1'b1, 2);
    chk("pp_count", count, 4);
    chk("pp_ovr", overrun, 0);
    for (int i = 1; i <= 4; i++)
      pop_one(8'h10 + 8'(i), "pp_order");
    chk("pp_drained", count, 0);

    rx_line = 1'b1;
    cyc(2);
    rx_line = 1'b0;
    cyc(192);
    chk("wd_pre_rst", rx_rst, 0);
    chk("wd_pre_ferr", framing_err, 0);
    cyc(1);
    chk("wd_rst1", rx_rst, 1);
    chk("wd_ferr", framing_err, 1);
    cyc(1);
    chk("wd_rst2", rx_rst, 1);
    cyc(1);
    chk("wd_rst_end", rx_rst, 0);
    rx_line = 1'b1;
    cyc(10);
    rx_line = 1'b0;
    cyc(1);
    chk("wd_glitch_rst", rx_rst, 0);
    send_frame(8'hA5, 1'b1, 1'b0, 16);
    chk("wd_rec_count", count, 1);
    chk("wd_rec_data", rd_data, 8'hA5);
    chk("wd_ferr_sticky", framing_err, 1);
    clear_errs();
    chk("wd_clr", framing_err, 0);

    rx_line = 1'b1;
    cyc(2);
    rx_line = 1'b0;
    cyc(5);
    enable = 1'b0;
    cyc(1);
    chk("en_rx_rst", rx_rst, 1);
    chk("en_count", count, 1);
    chk("en_data", rd_data, 8'hA5);
    rx_data = 8'h33;
    rx_line = 1'b1;
    rx_finished = 1'b1;
    cyc(12);
    chk("en_nopush", count, 1);
    chk("en_still_rst", rx_rst, 1);
    enable = 1'b1;
    rx_finished = 1'b0;
    cyc(2);
    chk("en_back", rx_rst, 0);
    chk("en_ferr", framing_err, 0);
    pop_one(8'hA5, "en_pop");
    chk("en_empty", count, 0);

    send_frame(8'h3C, 1'b1, 1'b0, 2);
    chk("mr_pre_count", count, 1);
    rx_line = 1'b1;
    cyc(2);
    rx_line = 1'b0;
    cyc(5);
    #2 reset = 1'b1;
    #1;
    chk("mr_count", count, 0);
    chk("mr_valid", rd_valid, 0);
    chk("mr_rx_rst", rx_rst, 1);
    chk("mr_data", rd_data, 8'h00);
    cyc(1);
    reset = 1'b0;
    cyc(2);
    send_frame(8'hC3, 1'b1, 1'b0, 2);
    chk("mr_new_count", count, 1);
    chk("mr_new_data", rd_data, 8'hC3);
    chk("mr_new_ferr", framing_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
